// File: rtl/uart_loader_pkg.sv
// Shared state encoding and command byte values for the UART program loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_CNT = 3'd1,
    LOAD_LO  = 3'd2,
    LOAD_HI  = 3'd3,
    WRITE    = 3'd4,
    RUN      = 3'd5,
    STEP     = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_ABORT = 8'h58;

endpackage

// File: rtl/word_assembler.sv
// Latches the low and high bytes of an instruction word as they arrive.
module word_assembler #(
  parameter int DBIT   = 8,
  parameter int INSN_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_done,
  input  logic [DBIT-1:0]   i_rx_data,
  input  logic              i_lo_sel,
  input  logic              i_hi_sel,
  output logic [INSN_W-1:0] word
);

  logic [DBIT-1:0] lo_byte;
  logic [DBIT-1:0] hi_byte;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      lo_byte <= '0;
      hi_byte <= '0;
    end else if (i_rx_done) begin
      if (i_lo_sel) lo_byte <= i_rx_data;
      if (i_hi_sel) hi_byte <= i_rx_data;
    end
  end

  assign word = {hi_byte, lo_byte};

endmodule

// File: rtl/uart_prog_loader.sv
// Command sequencer: loads instruction words into program memory and runs/steps the CPU.
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int INSN_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_done,
  input  logic [DBIT-1:0]   i_rx_data,
  input  logic              i_cpu_halt,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [INSN_W-1:0] o_mem_wdata,
  output logic              o_cpu_en,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  state_t              state, nxt;
  logic [7:0]          remaining;
  logic [ADDR_W-1:0]   addr;
  logic [INSN_W-1:0]   word;
  logic                is_cmd;

  word_assembler #(.DBIT(DBIT), .INSN_W(INSN_W)) u_word (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_rx_done (i_rx_done),
    .i_rx_data (i_rx_data),
    .i_lo_sel  (state == LOAD_LO),
    .i_hi_sel  (state == LOAD_HI),
    .word      (word)
  );

  assign is_cmd = (i_rx_data == CMD_LOAD) || (i_rx_data == CMD_RUN) ||
                  (i_rx_data == CMD_STEP) || (i_rx_data == CMD_ABORT);

  // NOTE: nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    nxt = state;
    case (state)
      IDLE:
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD)      nxt = LOAD_CNT;
          else if (i_rx_data == CMD_RUN)  nxt = RUN;
          else if (i_rx_data == CMD_STEP) nxt = STEP;
        end
      LOAD_CNT: if (i_rx_done) nxt = (i_rx_data == '0) ? DONE : LOAD_LO;
      LOAD_LO:  if (i_rx_done) nxt = LOAD_HI;
      LOAD_HI:  if (i_rx_done) nxt = WRITE;
      WRITE:    nxt = (remaining == 8'd1) ? DONE : LOAD_LO;
      RUN:
        // Abort takes priority over a halt seen in the same cycle.
        if (i_rx_done && i_rx_data == CMD_ABORT) nxt = IDLE;
        else if (i_cpu_halt)                     nxt = DONE;
      STEP:     nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= IDLE;
      remaining   <= '0;
      addr        <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_cpu_en    <= 1'b0;
      o_cpu_rst_n <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state <= nxt;

      if (state == LOAD_CNT && i_rx_done) begin
        remaining <= i_rx_data;
        addr      <= '0;
      end

      // The write pulse trails the WRITE state by one cycle, with address and data registered alongside.
      o_mem_we <= (state == WRITE);
      if (state == WRITE) begin
        o_mem_addr  <= addr;
        o_mem_wdata <= word;
        addr        <= addr + 1'b1;
        remaining   <= remaining - 8'd1;
      end

      // Level outputs follow the state being entered so they line up with it.
      o_cpu_en    <= (nxt == RUN) || (nxt == STEP);
      o_cpu_rst_n <= !(nxt inside {LOAD_CNT, LOAD_LO, LOAD_HI, WRITE});
      o_busy      <= (nxt != IDLE);
      o_done      <= (nxt == DONE);
      o_err       <= (state == IDLE) && i_rx_done && !is_cmd;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: load, run, step, errors, wrap and reset.
module tb_uart_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        halt = 1'b0;

  logic        mem_we, cpu_en, cpu_rst_n, busy, done, err;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;

  logic        b_we, b_en, b_rst_n, b_busy, b_done, b_err;
  logic [1:0]  b_addr;
  logic [15:0] b_wdata;

  uart_prog_loader dut (
    .i_clk(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_cpu_halt(halt), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_cpu_en(cpu_en), .o_cpu_rst_n(cpu_rst_n),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  uart_prog_loader #(.ADDR_W(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_cpu_halt(halt), .o_mem_we(b_we), .o_mem_addr(b_addr),
    .o_mem_wdata(b_wdata), .o_cpu_en(b_en), .o_cpu_rst_n(b_rst_n),
    .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int last_rx_cyc = 0;
  int en_cnt = 0, done_cnt = 0, err_cnt = 0, rst_hi_cnt = 0;
  int en_cyc = 0, done_cyc = 0;
  logic [26:0] wq[$];
  int          lat_q[$];
  logic [1:0]  bq[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_done) last_rx_cyc = cyc;
    if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      lat_q.push_back(cyc - last_rx_cyc);
    end
    if (b_we) bq.push_back(b_addr);
    if (cpu_en) begin en_cnt++; en_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
    if (busy && cpu_rst_n && !done) rst_hi_cnt++;
  end

  task automatic clr();
    en_cnt = 0; done_cnt = 0; err_cnt = 0; rst_hi_cnt = 0;
    wq.delete(); lat_q.delete(); bq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    idle(3);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    @(negedge clk);
    vectors++;
    if ({mem_we, cpu_en, cpu_rst_n, busy, done, err, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b en=%b rst_n=%b busy=%b done=%b err=%b addr=%h wdata=%h, want all 0",
               mem_we, cpu_en, cpu_rst_n, busy, done, err, mem_addr, mem_wdata);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rst_n=%b busy=%b, want rst_n=1 busy=0", cpu_rst_n, busy);
    end
  endtask

  task automatic test_load();
    clr();
    send_gap(8'h4C); send_gap(8'h02);
    send_gap(8'h34); send_gap(8'h12);
    send_gap(8'hCD); send_gap(8'hAB);
    idle(4);
    vectors++;
    if (wq.size() !== 2) begin
      miscompares++;
      $display("FAIL load_count: got %0d writes, want 2", wq.size());
    end else begin
      vectors++;
      if (wq[0] !== {11'd0, 16'h1234}) begin
        miscompares++;
        $display("FAIL load_w0: got addr=%h data=%h, want addr=000 data=1234", wq[0][26:16], wq[0][15:0]);
      end
      vectors++;
      if (wq[1] !== {11'd1, 16'hABCD}) begin
        miscompares++;
        $display("FAIL load_w1: got addr=%h data=%h, want addr=001 data=abcd", wq[1][26:16], wq[1][15:0]);
      end
      vectors++;
      if (lat_q[0] !== 2 || lat_q[1] !== 2) begin
        miscompares++;
        $display("FAIL load_latency: got %0d,%0d cycles, want 2,2", lat_q[0], lat_q[1]);
      end
    end
    vectors++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_done: got done=%0d busy=%b, want done=1 busy=0", done_cnt, busy);
    end
    vectors++;
    if (rst_hi_cnt !== 0) begin
      miscompares++;
      $display("FAIL load_cpu_reset: cpu_rst_n high for %0d load cycles, want 0", rst_hi_cnt);
    end
  endtask

  task automatic test_run();
    clr();
    send_byte(8'h52);
    idle(9);
    #1 halt = 1'b1;
    idle(4);
    #1 halt = 1'b0;
    @(negedge clk);
    vectors++;
    if (en_cnt !== 10 || done_cnt !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL run_halt: got en_cycles=%0d done=%0d busy=%b, want 10 1 0", en_cnt, done_cnt, busy);
    end
  endtask

  task automatic test_step();
    clr();
    send_byte(8'h53);
    idle(4);
    @(negedge clk);
    vectors++;
    if (en_cnt !== 1 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL step_pulse: got en_cycles=%0d done=%0d, want 1 1", en_cnt, done_cnt);
    end
    vectors++;
    if (done_cyc - en_cyc !== 1) begin
      miscompares++;
      $display("FAIL step_order: done came %0d cycles after en, want 1", done_cyc - en_cyc);
    end
  endtask

  task automatic test_error();
    clr();
    send_gap(8'h7F);
    @(negedge clk);
    vectors++;
    if (err_cnt !== 1 || busy !== 1'b0 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL err_unknown: got err=%0d busy=%b done=%0d, want 1 0 0", err_cnt, busy, done_cnt);
    end
    send_gap(8'h58);
    @(negedge clk);
    vectors++;
    if (err_cnt !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got err=%0d busy=%b, want 1 0", err_cnt, busy);
    end
  endtask

  task automatic test_abort_run();
    clr();
    send_byte(8'h52);
    idle(4);
    send_byte(8'h58);
    idle(3);
    @(negedge clk);
    vectors++;
    if (en_cnt !== 6 || done_cnt !== 0 || busy !== 1'b0 || cpu_en !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_run: got en_cycles=%0d done=%0d busy=%b en=%b, want 6 0 0 0",
               en_cnt, done_cnt, busy, cpu_en);
    end
    clr();
    send_byte(8'h52);
    idle(2);
    @(posedge clk); #1;
    rx_done = 1'b1; rx_data = 8'h58; halt = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0; halt = 1'b0;
    idle(3);
    @(negedge clk);
    vectors++;
    if (done_cnt !== 0 || busy !== 1'b0 || en_cnt !== 4) begin
      miscompares++;
      $display("FAIL abort_vs_halt: got done=%0d busy=%b en_cycles=%0d, want 0 0 4", done_cnt, busy, en_cnt);
    end
  endtask

  task automatic test_halt_on_entry();
    clr();
    halt = 1'b1;
    send_byte(8'h52);
    idle(4);
    #1 halt = 1'b0;
    @(negedge clk);
    vectors++;
    if (en_cnt !== 1 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL halt_on_entry: got en_cycles=%0d done=%0d, want 1 1", en_cnt, done_cnt);
    end
  endtask

  task automatic test_load_zero();
    clr();
    send_gap(8'h4C); send_gap(8'h00);
    @(negedge clk);
    vectors++;
    if (wq.size() !== 0 || done_cnt !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_zero: got writes=%0d done=%0d busy=%b, want 0 1 0", wq.size(), done_cnt, busy);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] words[5] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'hBEEF};
    clr();
    send_gap(8'h4C); send_gap(8'h05);
    for (int i = 0; i < 5; i++) begin
      send_gap(words[i][7:0]);
      send_gap(words[i][15:8]);
    end
    @(negedge clk);
    vectors++;
    if (bq.size() !== 5 || wq.size() !== 5) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d/%0d writes, want 5/5", bq.size(), wq.size());
    end else begin
      vectors++;
      if (bq[3] !== 2'd3 || bq[4] !== 2'd0) begin
        miscompares++;
        $display("FAIL wrap_addr: got 4th=%0d 5th=%0d, want 3 0", bq[3], bq[4]);
      end
      vectors++;
      if (wq[4] !== {11'd4, 16'hBEEF}) begin
        miscompares++;
        $display("FAIL wide_addr: got addr=%h data=%h, want addr=004 data=beef", wq[4][26:16], wq[4][15:0]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    clr();
    send_gap(8'h4C); send_gap(8'h03); send_byte(8'h11);
    #1 rst = 1'b0;
    idle(2);
    @(negedge clk);
    vectors++;
    if ({mem_we, cpu_en, cpu_rst_n, busy, done, err, mem_addr, mem_wdata} !== '0 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_load: got rst_n=%b busy=%b addr=%h wdata=%h done=%0d, want all 0",
               cpu_rst_n, busy, mem_addr, mem_wdata, done_cnt);
    end
    @(posedge clk); #1 rst = 1'b1;
    idle(2);
    clr();
    send_gap(8'h4C); send_gap(8'h01); send_gap(8'h78); send_gap(8'h56);
    @(negedge clk);
    vectors++;
    if (wq.size() !== 1 || wq[0] !== {11'd0, 16'h5678} || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL reload_after_reset: got writes=%0d first=%h done=%0d, want 1 {000,5678} 1",
               wq.size(), (wq.size() > 0) ? wq[0] : 27'h0, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_step();
    test_error();
    test_abort_run();
    test_halt_on_entry();
    test_load_zero();
    test_wrap();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
